// File: rtl/prbs_gen_if.sv
// prbs_gen_if -- word stream carrying generated PRBS words.
//   tdata  : OUT_W-bit word from the generator
//   tvalid : word valid, held until accepted
//   tready : downstream can accept the word this cycle
// modport master is the generator side, modport slave the consumer side.
`timescale 1ns/1ps
interface prbs_gen_if #(
    parameter int OUT_W = 32
);
    logic [OUT_W-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/prbs_gen.sv
// prbs_gen -- Fibonacci LFSR pattern generator with stream handshake,
// seed load and word-count limit. Each accepted word advances the LFSR
// by OUT_W single-bit steps through an unrolled next-state function.
//
// Ports
//   i_aclk, i_areset     clock, asynchronous active-high reset
//   i_seed_load, i_seed  load a seed while idle (zero seed -> DEFAULT_SEED)
//   i_start              idle -> run, samples i_num_words, clears o_word_cnt
//   i_stop               leave run after the next accepted word
//   i_num_words          words per run, 0 = unlimited
//   m_axis               word stream (tdata = top OUT_W bits of the LFSR)
//   o_busy               high while running
//   o_done               one-cycle pulse when a limited run completes
//   o_word_cnt           words accepted since the last start
//
// Build option: define PRBS_CHECK_EN to add a receive-side checker
// (i_chk_tdata, i_chk_tvalid, o_chk_err_cnt, o_chk_err). It owns its own
// LFSR, loaded together with the generator, and runs in every state.
//
// state | meaning
// IDLE  | no word offered; seed load and start accepted
// RUN   | word offered on m_axis; advances on every handshake
`timescale 1ns/1ps
module prbs_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(32'h8020_0003),
    parameter int               OUT_W        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h0000_ACE1),
    parameter int               CNT_W        = 32
) (
    input  logic             i_aclk,
    input  logic             i_areset,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_num_words,
    prbs_gen_if.master       m_axis,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_word_cnt
`ifdef PRBS_CHECK_EN
    ,
    input  logic [OUT_W-1:0] i_chk_tdata,
    input  logic             i_chk_tvalid,
    output logic [CNT_W-1:0] o_chk_err_cnt,
    output logic             o_chk_err
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // OUT_W single steps of s_next = {s[WIDTH-2:0], ^(s & TAPS)}
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s;
        for (int k = 0; k < OUT_W; k++) begin
            t = {t[WIDTH-2:0], ^(t & TAPS)};
        end
        return t;
    endfunction

    state_e           fsm_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] limit_q;
    logic             tvalid_q;
    logic             busy_q;
    logic             done_q;
    logic             stop_pend_q;

    logic [WIDTH-1:0] seed_eff;
    logic             hs;
    logic             last_word;

    // The all-zero state would lock up the LFSR, so a zero seed is replaced.
    assign seed_eff  = (i_seed == '0) ? DEFAULT_SEED : i_seed;
    assign hs        = tvalid_q & m_axis.tready;
    assign lfsr_d    = advance(lfsr_q);
    assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign last_word = (limit_q != '0) && (cnt_d == limit_q);

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            fsm_q       <= ST_IDLE;
            lfsr_q      <= DEFAULT_SEED;
            cnt_q       <= '0;
            limit_q     <= '0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    // Load lands in the same edge as start, so the first word is the new seed.
                    if (i_seed_load) begin
                        lfsr_q <= seed_eff;
                    end
                    if (i_start) begin
                        limit_q     <= i_num_words;
                        cnt_q       <= '0;
                        stop_pend_q <= 1'b0;
                        tvalid_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        fsm_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        lfsr_q <= lfsr_d;
                        cnt_q  <= cnt_d;
                        if (last_word) begin
                            done_q      <= 1'b1;
                            tvalid_q    <= 1'b0;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                            fsm_q       <= ST_IDLE;
                        end else if (stop_pend_q || i_stop) begin
                            tvalid_q    <= 1'b0;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                            fsm_q       <= ST_IDLE;
                        end
                    end else if (i_stop) begin
                        // Valid must not drop mid-word: remember the stop until the word goes.
                        stop_pend_q <= 1'b1;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = lfsr_q[WIDTH-1 -: OUT_W];
    assign m_axis.tvalid = tvalid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_word_cnt    = cnt_q;

`ifdef PRBS_CHECK_EN
    logic [WIDTH-1:0] chk_lfsr_q;
    logic [CNT_W-1:0] chk_cnt_q;
    logic             chk_err_q;
    logic             chk_mis;
    logic             chk_load;
    logic             chk_clr;

    assign chk_mis  = i_chk_tvalid && (i_chk_tdata != chk_lfsr_q[WIDTH-1 -: OUT_W]);
    assign chk_load = (fsm_q == ST_IDLE) && i_seed_load;
    assign chk_clr  = (fsm_q == ST_IDLE) && i_start;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            chk_lfsr_q <= DEFAULT_SEED;
            chk_cnt_q  <= '0;
            chk_err_q  <= 1'b0;
        end else begin
            chk_err_q <= chk_mis;
            if (chk_load) begin
                chk_lfsr_q <= seed_eff;
            end else if (i_chk_tvalid) begin
                chk_lfsr_q <= advance(chk_lfsr_q);
            end
            if (chk_clr) begin
                chk_cnt_q <= CNT_W'(chk_mis);
            end else if (chk_mis && (chk_cnt_q != '1)) begin
                chk_cnt_q <= chk_cnt_q + 1'b1;
            end
        end
    end

    assign o_chk_err_cnt = chk_cnt_q;
    assign o_chk_err     = chk_err_q;
`endif

endmodule

// File: tb/tb_prbs_gen.sv
`timescale 1ns/1ps
module tb_prbs_gen;

    localparam logic [31:0] D_TAPS = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Small instance: WIDTH=4, TAPS=4'h9, DEFAULT_SEED=4'h5
    logic       s_load, s_start, s_stop;
    logic [3:0] s_seed;
    logic [7:0] s_num, s_cnt;
    logic       s_busy, s_done;
    prbs_gen_if #(.OUT_W(4)) s_if ();

    // Default instance
    logic        d_load, d_start, d_stop;
    logic [31:0] d_seed, d_num, d_cnt;
    logic        d_busy, d_done;
    prbs_gen_if #(.OUT_W(32)) d_if ();

`ifdef PRBS_CHECK_EN
    logic       s_flip;
    logic [3:0] s_chk_tdata;
    logic       s_chk_tvalid;
    logic [7:0] s_chk_cnt;
    logic       s_chk_err;
    logic [31:0] d_chk_cnt;
    logic        d_chk_err;
    int          err_pulses = 0;
    assign s_chk_tvalid = s_if.tvalid & s_if.tready;
    assign s_chk_tdata  = s_if.tdata ^ {3'b000, s_flip};
`endif

    prbs_gen #(.WIDTH(4), .TAPS(4'h9), .OUT_W(4), .DEFAULT_SEED(4'h5), .CNT_W(8)) u_small (
        .i_aclk(clk), .i_areset(rst),
        .i_seed_load(s_load), .i_seed(s_seed), .i_start(s_start), .i_stop(s_stop),
        .i_num_words(s_num), .m_axis(s_if.master),
        .o_busy(s_busy), .o_done(s_done), .o_word_cnt(s_cnt)
`ifdef PRBS_CHECK_EN
        , .i_chk_tdata(s_chk_tdata), .i_chk_tvalid(s_chk_tvalid),
        .o_chk_err_cnt(s_chk_cnt), .o_chk_err(s_chk_err)
`endif
    );

    prbs_gen u_dflt (
        .i_aclk(clk), .i_areset(rst),
        .i_seed_load(d_load), .i_seed(d_seed), .i_start(d_start), .i_stop(d_stop),
        .i_num_words(d_num), .m_axis(d_if.master),
        .o_busy(d_busy), .o_done(d_done), .o_word_cnt(d_cnt)
`ifdef PRBS_CHECK_EN
        , .i_chk_tdata(32'h0), .i_chk_tvalid(1'b0),
        .o_chk_err_cnt(d_chk_cnt), .o_chk_err(d_chk_err)
`endif
    );

    logic [3:0]  s_q[$];
    logic [31:0] d_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: one word = 32 single steps, feedback by explicit tap scan.
    function automatic logic [31:0] madv(input logic [31:0] s);
        logic [31:0] t;
        logic        fb;
        t = s;
        for (int k = 0; k < 32; k++) begin
            fb = 1'b0;
            for (int b = 0; b < 32; b++) begin
                if (D_TAPS[b]) fb = fb ^ t[b];
            end
            t = {t[30:0], fb};
        end
        return t;
    endfunction

    // Monitor: pops expected words on every handshake, checks stall stability.
    logic        s_prev_stall = 1'b0, d_prev_stall = 1'b0;
    logic [3:0]  s_prev_data;
    logic [31:0] d_prev_data;
    always @(negedge clk) begin
        if (rst) begin
            s_prev_stall = 1'b0;
            d_prev_stall = 1'b0;
        end else begin
            if (s_if.tvalid && s_if.tready) begin
                if (s_q.size() == 0) check("s_unexpected_word", 32'(s_if.tdata), 32'hFFFF_FFFF);
                else check("s_word", 32'(s_if.tdata), 32'(s_q.pop_front()));
            end
            if (d_if.tvalid && d_if.tready) begin
                if (d_q.size() == 0) check("d_unexpected_word", d_if.tdata, 32'hFFFF_FFFF);
                else check("d_word", d_if.tdata, d_q.pop_front());
            end
            if (s_prev_stall) begin
                check("s_stall_valid", 32'(s_if.tvalid), 32'h1);
                check("s_stall_data", 32'(s_if.tdata), 32'(s_prev_data));
            end
            if (d_prev_stall) begin
                check("d_stall_valid", 32'(d_if.tvalid), 32'h1);
                check("d_stall_data", d_if.tdata, d_prev_data);
            end
            s_prev_stall = s_if.tvalid && !s_if.tready;
            s_prev_data  = s_if.tdata;
            d_prev_stall = d_if.tvalid && !d_if.tready;
            d_prev_data  = d_if.tdata;
`ifdef PRBS_CHECK_EN
            if (s_chk_err) err_pulses++;
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        logic [31:0] m;
        int          n_hs;

        s_load = 0; s_start = 0; s_stop = 0; s_seed = '0; s_num = '0; s_if.tready = 0;
        d_load = 0; d_start = 0; d_stop = 0; d_seed = '0; d_num = '0; d_if.tready = 0;
`ifdef PRBS_CHECK_EN
        s_flip = 0;
`endif
        #12;
        check("rst_s_tvalid", 32'(s_if.tvalid), 32'h0);
        check("rst_s_busy", 32'(s_busy), 32'h0);
        check("rst_s_done", 32'(s_done), 32'h0);
        check("rst_s_cnt", 32'(s_cnt), 32'h0);
        check("rst_s_tdata", 32'(s_if.tdata), 32'h5);
        check("rst_d_tdata", d_if.tdata, 32'h0000_ACE1);
        rst = 0;
        tick;

        // Seed 1, unlimited, continuous ready; load+start same cycle.
        s_seed = 4'h1; s_load = 1; s_start = 1; s_num = 8'd0; s_if.tready = 1;
        s_q.push_back(4'h1); s_q.push_back(4'hE); s_q.push_back(4'hB);
        s_q.push_back(4'h2); s_q.push_back(4'h3);
        tick;
        s_load = 0; s_start = 0;
        check("t1_busy", 32'(s_busy), 32'h1);
        check("t1_first", 32'(s_if.tdata), 32'h1);
        repeat (4) tick;
        s_stop = 1;
        tick;
        s_stop = 0;
        check("t1_busy_end", 32'(s_busy), 32'h0);
        check("t1_tvalid_end", 32'(s_if.tvalid), 32'h0);
        check("t1_done", 32'(s_done), 32'h0);
        check("t1_cnt", 32'(s_cnt), 32'h5);

        // Limited run of 3, then restart continues the sequence.
        s_seed = 4'h1; s_load = 1; s_start = 1; s_num = 8'd3;
        s_q.push_back(4'h1); s_q.push_back(4'hE); s_q.push_back(4'hB);
        tick;
        s_load = 0; s_start = 0;
        tick; tick; tick;
        check("t2_done", 32'(s_done), 32'h1);
        check("t2_busy", 32'(s_busy), 32'h0);
        check("t2_cnt", 32'(s_cnt), 32'h3);
        tick;
        check("t2_done_pulse", 32'(s_done), 32'h0);
        s_start = 1; s_num = 8'd2;
        s_q.push_back(4'h2); s_q.push_back(4'h3);
        tick;
        s_start = 0;
        tick; tick;
        check("t2r_done", 32'(s_done), 32'h1);
        check("t2r_cnt", 32'(s_cnt), 32'h2);
        tick;
        check("t2r_done_pulse", 32'(s_done), 32'h0);

        // Stop during a stall: one more handshake, no done.
        s_if.tready = 0;
        s_seed = 4'hB; s_load = 1; s_start = 1; s_num = 8'd0;
        tick;
        s_load = 0; s_start = 0;
        tick; tick;
        check("t5_stall_data", 32'(s_if.tdata), 32'hB);
        s_stop = 1;
        tick;
        s_stop = 0;
        tick;
        check("t5_still_busy", 32'(s_busy), 32'h1);
        check("t5_still_valid", 32'(s_if.tvalid), 32'h1);
        s_q.push_back(4'hB);
        s_if.tready = 1;
        tick;
        s_if.tready = 0;
        check("t5_busy", 32'(s_busy), 32'h0);
        check("t5_done", 32'(s_done), 32'h0);
        check("t5_cnt", 32'(s_cnt), 32'h1);

`ifdef PRBS_CHECK_EN
        // Loop back through the checker, corrupt word 5.
        s_seed = 4'h1; s_load = 1; s_start = 1; s_num = 8'd0; s_if.tready = 1;
        s_q.push_back(4'h1); s_q.push_back(4'hE); s_q.push_back(4'hB); s_q.push_back(4'h2);
        s_q.push_back(4'h3); s_q.push_back(4'hD); s_q.push_back(4'h6);
        tick;
        s_load = 0; s_start = 0;
        err_pulses = 0;
        repeat (4) tick;
        s_flip = 1;
        tick;
        s_flip = 0;
        tick;
        s_stop = 1;
        tick;
        s_stop = 0; s_if.tready = 0;
        tick;
        check("chk_cnt_words", 32'(s_cnt), 32'h7);
        check("chk_err_cnt", 32'(s_chk_cnt), 32'h1);
        check("chk_err_pulses", 32'(err_pulses), 32'h1);
`endif

        // Default params: zero seed -> DEFAULT_SEED, irregular ready, load in RUN ignored.
        pat = 16'hB2E5;
        m = 32'h0000_ACE1;
        n_hs = 0;
        for (int i = 0; i < 16; i++) begin
            if (pat[i]) begin
                d_q.push_back(m);
                m = madv(m);
                n_hs++;
            end
        end
        d_q.push_back(m);
        n_hs++;
        d_seed = 32'h0; d_load = 1; d_start = 1; d_num = 32'd0;
        tick;
        d_load = 0; d_start = 0;
        check("t4_first_word", d_if.tdata, 32'h0000_ACE1);
        check("t4_busy", 32'(d_busy), 32'h1);
        for (int i = 0; i < 16; i++) begin
            d_if.tready = pat[i];
            if (i == 5) begin
                d_load = 1;
                d_seed = 32'h1234_5678;
            end else begin
                d_load = 0;
            end
            tick;
        end
        d_load = 0; d_if.tready = 0; d_stop = 1;
        tick;
        d_stop = 0;
        tick;
        check("t3_stop_valid", 32'(d_if.tvalid), 32'h1);
        d_if.tready = 1;
        tick;
        d_if.tready = 0;
        check("t3_busy", 32'(d_busy), 32'h0);
        check("t3_done", 32'(d_done), 32'h0);
        check("t3_cnt", d_cnt, 32'(n_hs));

        // Reset mid-run.
        s_seed = 4'h1; s_load = 1; s_start = 1; s_num = 8'd0; s_if.tready = 1;
        s_q.push_back(4'h1); s_q.push_back(4'hE);
        tick;
        s_load = 0; s_start = 0;
        tick; tick;
        rst = 1;
        #1;
        check("rr_tvalid", 32'(s_if.tvalid), 32'h0);
        check("rr_busy", 32'(s_busy), 32'h0);
        check("rr_cnt", 32'(s_cnt), 32'h0);
        check("rr_tdata", 32'(s_if.tdata), 32'h5);
        tick;
        check("rr_done", 32'(s_done), 32'h0);
        check("rr_tvalid_hold", 32'(s_if.tvalid), 32'h0);
        rst = 0;
        s_if.tready = 0;
        tick;

        check("s_queue_empty", 32'(s_q.size()), 32'h0);
        check("d_queue_empty", 32'(d_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
